// File: rtl/array_2_port_arbiter.sv
// Two-requester front end for a single array_2 register array.
// After reset or a flush it sweeps every set to init_value. Otherwise it
// grants at most one read and one write per cycle and round-robins between
// A and B when both want the same kind of access. Read data follows the
// array's registered output by one cycle and is held until the next return.
module array_2_port_arbiter #(
  parameter int               s_index    = 3,
  parameter int               width      = 1,
  parameter logic [width-1:0] init_value = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_req_i,
  output logic               busy_o,
  input  logic               a_req_i,
  input  logic               a_we_i,
  input  logic [s_index-1:0] a_idx_i,
  input  logic [width-1:0]   a_wdata_i,
  output logic               a_gnt_o,
  output logic               a_rvalid_o,
  output logic [width-1:0]   a_rdata_o,
  input  logic               b_req_i,
  input  logic               b_we_i,
  input  logic [s_index-1:0] b_idx_i,
  input  logic [width-1:0]   b_wdata_i,
  output logic               b_gnt_o,
  output logic               b_rvalid_o,
  output logic [width-1:0]   b_rdata_o,
  output logic               arr_read_o,
  output logic               arr_load_o,
  output logic [s_index-1:0] arr_rindex_o,
  output logic [s_index-1:0] arr_windex_o,
  output logic [width-1:0]   arr_datain_o,
  input  logic [width-1:0]   arr_dataout_i
);

  localparam logic [s_index-1:0] LastIdx = '1;

  typedef enum logic {SWEEP, SERVE} state_e;
  typedef enum logic {RR_A, RR_B} rr_e;

  state_e             state_q, state_d;
  rr_e                rr_q, rr_d;
  logic [s_index-1:0] cnt_q, cnt_d;
  logic               aGnt, bGnt;
  logic               aRvalid_q, aRvalid_d;
  logic               bRvalid_q, bRvalid_d;
  logic [width-1:0]   aRdata_q, bRdata_q;

  // Next state, grant decision and array drive; the sweep owns the write port,
  // and a flush request suppresses every grant in the cycle it arrives.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    aGnt         = 1'b0;
    bGnt         = 1'b0;
    arr_read_o   = 1'b0;
    arr_load_o   = 1'b0;
    arr_rindex_o = '0;
    arr_windex_o = '0;
    arr_datain_o = '0;
    case (state_q)
      SWEEP: begin
        arr_load_o   = 1'b1;
        arr_windex_o = cnt_q;
        arr_datain_o = init_value;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = SERVE;
        end
      end
      default: begin
        if (flush_req_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else begin
          if (a_req_i && b_req_i && (a_we_i == b_we_i)) begin
            if (rr_q == RR_A) begin
              aGnt = 1'b1;
              rr_d = RR_B;
            end else begin
              bGnt = 1'b1;
              rr_d = RR_A;
            end
          end else begin
            aGnt = a_req_i;
            bGnt = b_req_i;
          end
          if (aGnt) begin
            if (a_we_i) begin
              arr_load_o   = 1'b1;
              arr_windex_o = a_idx_i;
              arr_datain_o = a_wdata_i;
            end else begin
              arr_read_o   = 1'b1;
              arr_rindex_o = a_idx_i;
            end
          end
          if (bGnt) begin
            if (b_we_i) begin
              arr_load_o   = 1'b1;
              arr_windex_o = b_idx_i;
              arr_datain_o = b_wdata_i;
            end else begin
              arr_read_o   = 1'b1;
              arr_rindex_o = b_idx_i;
            end
          end
        end
      end
    endcase
  end

  assign aRvalid_d = aGnt & ~a_we_i;
  assign bRvalid_d = bGnt & ~b_we_i;

  // Controller state and read-return pipeline; reset restarts the sweep and
  // discards any read return still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SWEEP;
      cnt_q     <= '0;
      rr_q      <= RR_A;
      aRvalid_q <= 1'b0;
      bRvalid_q <= 1'b0;
      aRdata_q  <= '0;
      bRdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      aRvalid_q <= aRvalid_d;
      bRvalid_q <= bRvalid_d;
      if (aRvalid_q) begin
        aRdata_q <= arr_dataout_i;
      end
      if (bRvalid_q) begin
        bRdata_q <= arr_dataout_i;
      end
    end
  end

  assign busy_o     = (state_q == SWEEP);
  assign a_gnt_o    = aGnt;
  assign b_gnt_o    = bGnt;
  assign a_rvalid_o = aRvalid_q;
  assign b_rvalid_o = bRvalid_q;
  assign a_rdata_o  = aRvalid_q ? arr_dataout_i : aRdata_q;
  assign b_rdata_o  = bRvalid_q ? arr_dataout_i : bRdata_q;

endmodule

// File: doc/array_2_port_arbiter.md
Name: array_2_port_arbiter

Overview:
- Shares one array_2 register array (tag, valid or LRU storage) between two cache-side requesters, A and B.
- Serves at most one read and one write per cycle, and round-robins between requesters on same-type conflicts.
- Returns read data aligned to the array's registered output.
- Sweeps every set to a fixed init value after reset and whenever flush_req is pulsed; no requester can touch the array during a sweep.

Parameters:
- s_index, 3, index width; num_sets = 2**s_index.
- width, 1, data width per set.
- init_value, '0, value written to every set during a sweep.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- flush_req  input  1  one-cycle pulse that starts a sweep.
- busy  output  1  high while a sweep is in progress.
- a_req / b_req  input  1  request valid; held until granted.
- a_we / b_we  input  1  1 = write, 0 = read.
- a_idx / b_idx  input  s_index  set index.
- a_wdata / b_wdata  input  width  write data.
- a_gnt / b_gnt  output  1  combinational grant in the same cycle.
- a_rvalid / b_rvalid  output  1  read data valid; one-cycle pulse.
- a_rdata / b_rdata  output  width  read data.
- arr_read  output  1  to array_2 read.
- arr_load  output  1  to array_2 load.
- arr_rindex  output  s_index  to array_2 rindex.
- arr_windex  output  s_index  to array_2 windex.
- arr_datain  output  width  to array_2 datain.
- arr_dataout  input  width  from array_2 dataout.

Behaviour:
- States:
  - SWEEP: entered on reset and on flush_req in SERVE.
  - SERVE.
  - The sweep counter cnt is s_index bits wide.
- Reset (rst low, async):
  - state=SWEEP, cnt=0, rr=A.
  - busy=1, all gnt=0, all rvalid=0, all rdata=0.
- SWEEP, each cycle:
  - arr_load=1, arr_windex=cnt, arr_datain=init_value, arr_read=0, no grants.
  - cnt increments each cycle. At cnt==num_sets-1, go to SERVE and clear cnt.
  - Total num_sets cycles; busy falls the cycle after the last write.
  - flush_req during SWEEP is ignored.
- SERVE, grant rules (combinational on req/we):
  - Only A requests, or only B requests: that requester is granted.
  - One read and one write from different requesters: both granted. arr_read and arr_load both assert; same-index forwarding comes from array_2.
  - Both read, or both write: grant the requester pointed to by rr. rr then flips to the other requester.
  - rr changes only on a conflict.
- Array drive on grant:
  - Read: arr_read=1, arr_rindex=idx.
  - Write: arr_load=1, arr_windex=idx, arr_datain=wdata.
  - Unused array ports hold 0. Non-granted requesters must hold their request.
- Read return:
  - A read granted in cycle t gives x_rvalid=1 and x_rdata=arr_dataout in cycle t+1.
  - x_rdata holds its value until the next rvalid.
- flush_req in SERVE:
  - Takes effect that cycle. No grants issue that cycle; next state is SWEEP.
  - An rvalid owed from a grant in the previous cycle is still delivered.
  - busy rises the cycle after flush_req.
- Reset mid-sweep or mid-read: restarts the sweep from cnt=0 and drops any pending rvalid.
- cnt wraps naturally; no overflow flag.

Test Plan (s_index=3, width=4, init_value=4'h0):
- Release reset -> busy=1 for 8 cycles; arr_windex walks 0..7 with arr_load=1 and arr_datain=0; busy=0 on cycle 9; no gnt during the sweep.
- Write, then read back:
  - A writes idx 3 with data 4'hA -> a_gnt=1 that cycle.
  - A then reads idx 3 -> a_rvalid=1 and a_rdata=4'hA exactly one cycle after a_gnt.
- A and B both read, 3 consecutive cycles:
  - rr=A initially -> grants go A, B, A.
  - Each rvalid arrives one cycle after its grant to the correct requester.
- Same-cycle read/write to the same index:
  - A writes idx 5 with 4'h7 while B reads idx 5 -> a_gnt=b_gnt=1.
  - Next cycle b_rdata=4'h7 (forwarded).
- Flush after data is written:
  - Write idx 2 with 4'hF, pulse flush_req, keep a_req high -> no a_gnt for 9 cycles.
  - After busy falls, a read of idx 2 returns 4'h0.
- Reset pulled low mid-sweep at cnt=4 -> cnt returns to 0, busy stays 1, and a full 8-cycle sweep follows.
